// File: rtl/alu_pkg.sv
// Shared types for the ALU result collector: command encodings, flag bit positions,
// the captured-result record and the latency-tracker slot.
package alu_pkg;

    localparam int ALU_OP_W  = 8;
    localparam int ALU_CMD_W = 4;
    localparam int ALU_RES_W = 2 * ALU_OP_W;
    localparam int FLAG_W    = 6;

    localparam logic [ALU_CMD_W-1:0] ALU_MUL_CMD0 = 4'd9;
    localparam logic [ALU_CMD_W-1:0] ALU_MUL_CMD1 = 4'd10;

    // Bit positions inside the packed {cout,oflow,g,l,e,err} flag vector.
    localparam int FLAG_COUT  = 5;
    localparam int FLAG_OFLOW = 4;
    localparam int FLAG_G     = 3;
    localparam int FLAG_L     = 2;
    localparam int FLAG_E     = 1;
    localparam int FLAG_ERR   = 0;

    typedef struct packed {
        logic [ALU_RES_W-1:0] res;
        logic                 cout;
        logic                 oflow;
        logic                 g;
        logic                 l;
        logic                 e;
        logic                 err;
        logic [ALU_CMD_W-1:0] cmd;
        logic                 mode;
    } alu_res_t;

    typedef struct packed {
        logic                 vld;
        logic [ALU_CMD_W-1:0] cmd;
        logic                 mode;
        logic [1:0]           rem;
    } slot_t;

    function automatic logic [1:0] op_latency(
        input logic                 mode,
        input logic [ALU_CMD_W-1:0] cmd,
        input logic [ALU_CMD_W-1:0] mul0,
        input logic [ALU_CMD_W-1:0] mul1
    );
        if (mode && ((cmd == mul0) || (cmd == mul1))) begin
            return 2'd2;
        end
        return 2'd1;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// In-order FIFO of captured ALU results with a registered head; a push into an empty
// FIFO is visible one cycle later, and a push while full is accepted only alongside a pop.
module alu_res_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  alu_res_t      push_dat_i,
    input  logic          pop_i,
    output alu_res_t      head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    alu_res_t      mem_q [DEPTH];
    alu_res_t      head_q, head_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != FULL_CNT) || pop_ok);
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Head register tracks the next head; when that slot is being written this
        // cycle the incoming entry is forwarded. An emptied FIFO keeps the last head.
        head_d = head_q;
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_dat_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_dat_o = head_q;
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/alu_result_collector.sv
// Snoops ALU issues, captures res/flags 1 or 2 enabled cycles later into an in-order FIFO;
// head is valid/ready, results arriving while full and not popping are dropped and counted.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int                   OP_WIDTH  = ALU_OP_W,
    parameter int                   CMD_WIDTH = ALU_CMD_W,
    parameter int                   RES_W     = 2 * OP_WIDTH,
    parameter int                   DEPTH     = 8,
    parameter logic [CMD_WIDTH-1:0] MUL_CMD0  = ALU_MUL_CMD0,
    parameter logic [CMD_WIDTH-1:0] MUL_CMD1  = ALU_MUL_CMD1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     mode,
    input  logic [1:0]               inp_valid,
    input  logic [CMD_WIDTH-1:0]     cmd,
    input  logic [RES_W-1:0]         res,
    input  logic                     cout,
    input  logic                     oflow,
    input  logic                     g,
    input  logic                     l,
    input  logic                     e,
    input  logic                     err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_res,
    output logic [FLAG_W-1:0]        out_flags,
    output logic [CMD_WIDTH-1:0]     out_cmd,
    output logic                     out_mode,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt,
    output logic                     coll_err
);

    slot_t      s0_q, s0_d;
    slot_t      s1_q, s1_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       coll_err_q, coll_err_d;

    logic       issue, mature0, mature1;
    logic       push, pop, drop;
    logic       fifo_full, fifo_empty;
    alu_res_t   push_dat, head;

    always_comb begin
        s0_d       = s0_q;
        s1_d       = s1_q;
        coll_err_d = coll_err_q;
        drop_cnt_d = drop_cnt_q;

        issue   = ce && (inp_valid != 2'b00);
        mature0 = s0_q.vld && (s0_q.rem == 2'd1);
        mature1 = s1_q.vld;
        push    = ce && (mature0 || mature1);

        // When a multiply and the following 1-cycle op mature together, the ALU output
        // belongs to the younger op, so its cmd/mode tag the single captured entry.
        push_dat       = '0;
        push_dat.res   = res;
        push_dat.cout  = cout;
        push_dat.oflow = oflow;
        push_dat.g     = g;
        push_dat.l     = l;
        push_dat.e     = e;
        push_dat.err   = err;
        push_dat.cmd   = mature0 ? s0_q.cmd  : s1_q.cmd;
        push_dat.mode  = mature0 ? s0_q.mode : s1_q.mode;

        if (ce) begin
            s0_d = '0;
            s1_d = '0;
            if (issue) begin
                s0_d.vld  = 1'b1;
                s0_d.cmd  = cmd;
                s0_d.mode = mode;
                s0_d.rem  = op_latency(mode, cmd, MUL_CMD0, MUL_CMD1);
            end
            if (s0_q.vld && (s0_q.rem == 2'd2)) begin
                s1_d.vld  = 1'b1;
                s1_d.cmd  = s0_q.cmd;
                s1_d.mode = s0_q.mode;
                s1_d.rem  = 2'd1;
            end
            if (mature0 && mature1) begin
                coll_err_d = 1'b1;
            end
        end

        pop  = out_ready && !fifo_empty;
        drop = push && fifo_full && !pop;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q       <= '0;
            s1_q       <= '0;
            drop_cnt_q <= '0;
            coll_err_q <= 1'b0;
        end else begin
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            drop_cnt_q <= drop_cnt_d;
            coll_err_q <= coll_err_d;
        end
    end

    alu_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (out_ready),
        .head_dat_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (count)
    );

    always_comb begin
        out_flags             = '0;
        out_flags[FLAG_COUT]  = head.cout;
        out_flags[FLAG_OFLOW] = head.oflow;
        out_flags[FLAG_G]     = head.g;
        out_flags[FLAG_L]     = head.l;
        out_flags[FLAG_E]     = head.e;
        out_flags[FLAG_ERR]   = head.err;
    end

    assign out_valid = !fifo_empty;
    assign out_res   = head.res;
    assign out_cmd   = head.cmd;
    assign out_mode  = head.mode;
    assign drop_cnt  = drop_cnt_q;
    assign coll_err  = coll_err_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench: expected entries are queued as stimulus is driven and compared as the
// collector presents them.
module tb_alu_result_collector;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        mode;
    logic [1:0]  inp_valid;
    logic [3:0]  cmd;
    logic [15:0] res;
    logic [5:0]  flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [5:0]  out_flags;
    logic [3:0]  out_cmd;
    logic        out_mode;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    logic        coll_err;

    int errors;
    int checks;

    typedef struct {
        logic [15:0] res;
        logic [5:0]  flags;
        logic [3:0]  cmd;
        logic        mode;
    } exp_t;

    exp_t sb[$];

    alu_result_collector dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .mode      (mode),
        .inp_valid (inp_valid),
        .cmd       (cmd),
        .res       (res),
        .cout      (flags[5]),
        .oflow     (flags[4]),
        .g         (flags[3]),
        .l         (flags[2]),
        .e         (flags[1]),
        .err       (flags[0]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags),
        .out_cmd   (out_cmd),
        .out_mode  (out_mode),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .coll_err  (coll_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic [5:0] f,
                                input logic [3:0] c, input logic m);
        exp_t x;
        x.res   = r;
        x.flags = f;
        x.cmd   = c;
        x.mode  = m;
        return x;
    endfunction

    // Single-cycle op: issue, then present its result on the capture edge.
    task automatic issue1(input logic [3:0] c, input logic m, input logic [15:0] r,
                          input logic [5:0] f);
        ce        = 1'b1;
        inp_valid = 2'b01;
        cmd       = c;
        mode      = m;
        tick();
        inp_valid = 2'b00;
        res       = r;
        flags     = f;
        sb.push_back(mk(r, f, c, m));
        tick();
    endtask

    task automatic drain(input string tag);
        exp_t        x;
        int          guard;
        logic [15:0] last;
        guard     = 0;
        last      = out_res;
        out_ready = 1'b1;
        while (sb.size() != 0 && guard < 40) begin
            if (out_valid) begin
                x = sb.pop_front();
                chk({tag, "_res"},   32'(out_res),   32'(x.res));
                chk({tag, "_flags"}, 32'(out_flags), 32'(x.flags));
                chk({tag, "_cmd"},   32'(out_cmd),   32'(x.cmd));
                chk({tag, "_mode"},  32'(out_mode),  32'(x.mode));
                last = x.res;
            end
            guard++;
            tick();
        end
        out_ready = 1'b0;
        chk({tag, "_pending"},   32'(sb.size()),  32'd0);
        chk({tag, "_vld_empty"}, 32'(out_valid),  32'd0);
        chk({tag, "_hold"},      32'(out_res),    32'(last));
    endtask

    initial begin
        exp_t x;
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        ce        = 1'b0;
        mode      = 1'b0;
        inp_valid = 2'b00;
        cmd       = 4'd0;
        res       = 16'd0;
        flags     = 6'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (5) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_res",   32'(out_res),   32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);
        chk("rst_cmd",   32'(out_cmd),   32'd0);
        chk("rst_mode",  32'(out_mode),  32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        chk("rst_coll",  32'(coll_err),  32'd0);
        rst = 1'b1;

        // First op straight after reset release
        issue1(4'd0, 1'b1, 16'h001E, 6'h01);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_res",   32'(out_res),   32'h001E);
        drain("t1");

        // Multiply: only the value on res two edges after issue is captured
        ce        = 1'b1;
        inp_valid = 2'b01;
        mode      = 1'b1;
        cmd       = 4'd9;
        tick();
        inp_valid = 2'b00;
        res       = 16'hDEAD;
        flags     = 6'h3F;
        tick();
        chk("t2_count_t1", 32'(count), 32'd0);
        res   = 16'h0190;
        flags = 6'h12;
        sb.push_back(mk(16'h0190, 6'h12, 4'd9, 1'b1));
        tick();
        chk("t2_count_t2", 32'(count), 32'd1);
        res = 16'h5555;
        tick();
        chk("t2_count_t3", 32'(count), 32'd1);
        drain("t2");

        // Second multiply encoding with ce low in flight: tracker freezes
        inp_valid = 2'b01;
        mode      = 1'b1;
        cmd       = 4'd10;
        tick();
        inp_valid = 2'b00;
        ce        = 1'b0;
        res       = 16'hAAAA;
        tick();
        tick();
        chk("frz_count_a", 32'(count), 32'd0);
        ce  = 1'b1;
        res = 16'h7777;
        tick();
        chk("frz_count_b", 32'(count), 32'd0);
        res   = 16'h0A0A;
        flags = 6'h21;
        sb.push_back(mk(16'h0A0A, 6'h21, 4'd10, 1'b1));
        tick();
        chk("frz_count_c", 32'(count), 32'd1);
        drain("frz");

        // Ten back-to-back logical ops into a stalled consumer: last two dropped
        out_ready = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                ce        = 1'b1;
                inp_valid = 2'b10;
                mode      = 1'b0;
                cmd       = 4'(i);
            end else begin
                inp_valid = 2'b00;
            end
            if (i > 0) begin
                res   = 16'h0100 + 16'(i - 1);
                flags = 6'((i - 1) ^ 21);
                if (i - 1 < 8) begin
                    sb.push_back(mk(res, flags, 4'(i - 1), 1'b0));
                end
            end
            tick();
        end
        chk("t3_count", 32'(count),     32'd8);
        chk("t3_drop",  32'(drop_cnt),  32'd2);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_head",  32'(out_res),   32'h0100);

        // Push into a full FIFO while the head is popped
        inp_valid = 2'b11;
        mode      = 1'b0;
        cmd       = 4'd3;
        tick();
        inp_valid = 2'b00;
        res       = 16'h0200;
        flags     = 6'h2A;
        out_ready = 1'b1;
        x = sb.pop_front();
        chk("t4_pop_res", 32'(out_res),   32'(x.res));
        chk("t4_pop_cmd", 32'(out_cmd),   32'(x.cmd));
        sb.push_back(mk(16'h0200, 6'h2A, 4'd3, 1'b0));
        tick();
        out_ready = 1'b0;
        chk("t4_count", 32'(count),    32'd8);
        chk("t4_drop",  32'(drop_cnt), 32'd2);
        chk("t4_head",  32'(out_res),  32'h0101);
        drain("t4");

        // Collision: multiply then add on consecutive edges
        chk("t5_coll_before", 32'(coll_err), 32'd0);
        inp_valid = 2'b01;
        mode      = 1'b1;
        cmd       = 4'd9;
        tick();
        cmd = 4'd0;
        tick();
        inp_valid = 2'b00;
        res       = 16'h0042;
        flags     = 6'h0C;
        sb.push_back(mk(16'h0042, 6'h0C, 4'd0, 1'b1));
        tick();
        chk("t5_count", 32'(count),    32'd1);
        chk("t5_coll",  32'(coll_err), 32'd1);
        res = 16'h1234;
        tick();
        chk("t5_count_after", 32'(count),    32'd1);
        chk("t5_coll_sticky", 32'(coll_err), 32'd1);
        drain("t5");

        // Reset with buffered entries and a multiply in flight
        issue1(4'd1, 1'b0, 16'h0301, 6'h01);
        issue1(4'd2, 1'b0, 16'h0302, 6'h02);
        issue1(4'd4, 1'b0, 16'h0303, 6'h03);
        inp_valid = 2'b01;
        mode      = 1'b1;
        cmd       = 4'd9;
        tick();
        inp_valid = 2'b00;
        chk("t6_count_pre", 32'(count), 32'd3);
        rst = 1'b0;
        #1;
        chk("t6_count_rst", 32'(count),     32'd0);
        chk("t6_valid_rst", 32'(out_valid), 32'd0);
        chk("t6_res_rst",   32'(out_res),   32'd0);
        chk("t6_coll_rst",  32'(coll_err),  32'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b1;
        res = 16'h9999;
        repeat (4) tick();
        chk("t6_count_post", 32'(count),     32'd0);
        chk("t6_valid_post", 32'(out_valid), 32'd0);
        chk("t6_drop_post",  32'(drop_cnt),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
